snake_tick_gen: RTL and testbench
=================================

SNAKE_TICK_GEN -- requirements
Module: snake_tick_gen

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 50_000_000, tick period in clk_i cycles at speed level 0.
REQ-002 SHALL have parameter NO_LEVELS, default 8, number of speed levels (2..16).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, number of stable samples required to accept a key change.
REQ-004 SHALL have port clk_i, input, 1, single system clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port key_faster_ni, input, 1, raw asynchronous push-button, active-low.
REQ-007 SHALL have port key_slower_ni, input, 1, raw asynchronous push-button, active-low.
REQ-008 SHALL have port key_pause_ni, input, 1, raw asynchronous push-button, active-low.
REQ-009 SHALL have port enable_o, output, 1, one-cycle step strobe that drives the LED snake stage's enable_i.
REQ-010 SHALL have port level_o, output, $clog2(NO_LEVELS), current speed level.
REQ-011 SHALL have port paused_o, output, 1, high while stepping is paused.

Function
REQ-012 SHALL pass each key through a 2-FF synchronizer, then through a debouncer.
REQ-013 The debouncer SHALL update its stable value only after DEBOUNCE_CYCLES consecutive equal synchronized samples; any differing sample SHALL restart the count.
REQ-014 The debouncer SHALL emit a one-cycle press pulse on a stable 1->0 transition; a release SHALL emit no pulse.
REQ-015 For a clean key edge, the press pulse SHALL occur exactly DEBOUNCE_CYCLES+3 cycles after the first low sample.
REQ-016 The tick period SHALL be BASE_PERIOD >> level_o cycles, with a minimum of 1.
REQ-017 The period counter SHALL count 0..period-1; at period-1, if not paused, it SHALL assert enable_o for exactly one cycle and wrap to 0.
REQ-018 While paused, the counter SHALL hold its value and enable_o SHALL stay 0.
REQ-019 A faster press SHALL increment level_o, saturating at NO_LEVELS-1; a slower press SHALL decrement it, saturating at 0.
REQ-020 A level change SHALL clear the counter on the same edge; a saturated (no-op) press SHALL leave the counter untouched.
REQ-021 Faster and slower press pulses in the same cycle SHALL be ignored: no level change and no counter clear.
REQ-022 A pause press SHALL toggle paused_o on the next edge.
REQ-023 On resume, counting SHALL continue from the held counter value.
REQ-024 enable_o SHALL never be high on two consecutive cycles, except at period 1 when not paused.

Reset
REQ-025 On rst_ni low, all outputs and state SHALL be cleared asynchronously: enable_o=0, level_o=0, paused_o=0, counter=0, synchronizers=1, debounce stable values=1, debounce counts=0.
REQ-026 Reset mid-period SHALL discard any partial count and any pending debounce.
REQ-027 Reset release SHALL be the only reset synchronization.

Configuration
REQ-028 Macro SNAKE_TICK_SINGLE_STEP_EN SHALL select the single-step feature.
REQ-029 When SNAKE_TICK_SINGLE_STEP_EN is defined, a faster press while paused SHALL produce exactly one enable_o pulse on the next cycle instead of changing the level.
REQ-030 When SNAKE_TICK_SINGLE_STEP_EN is not defined, a faster press while paused SHALL change the level per REQ-019/020, and enable_o SHALL stay 0.

Structure
REQ-031 A shared package (snake_pkg) SHALL hold the default constants (BASE_PERIOD, DEBOUNCE_CYCLES, NO_LEVELS) and the level-width expression.
REQ-032 Sub-module key_debounce (synchronizer + debounce + press pulse) SHALL be instantiated three times.
REQ-033 The period shifter, level register, pause flag and counter SHALL live in snake_tick_gen.

Verification (BASE_PERIOD=16, NO_LEVELS=4, DEBOUNCE_CYCLES=4)
REQ-034 No keys pressed, 64 cycles after reset -> enable_o pulses at cycles 16, 32, 48 and 64, each one cycle wide; level_o=0.
REQ-035 Faster key held 20 cycles -> one press pulse 7 cycles after the edge; level_o=1; counter cleared; next enable_o 8 cycles later.
REQ-036 Faster pressed 5 times -> level_o saturates at 3, period 2; slower pressed 5 times -> level_o=0, and no counter clear on the saturated press.
REQ-037 Key bouncing low/high every 2 cycles for 20 cycles, then held low -> exactly one press pulse, 7 cycles after the final stable low.
REQ-038 Pause pressed at counter=9 -> enable_o stays 0 for 100 cycles; pause pressed again -> first enable_o 6 cycles after resume (+1 with single-step: faster press while paused gives one pulse).
REQ-039 rst_ni asserted at counter=12 with level_o=2 -> all outputs 0 immediately; after release, first enable_o after 16 cycles.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared defaults and width helpers for the snake tick generator.
// Latency: none, constants and pure functions only.
// Backpressure: none.
package snake_pkg;

    localparam int unsigned BASE_PERIOD_DEF     = 50_000_000;
    localparam int unsigned NO_LEVELS_DEF       = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;

    // Width of the speed level: $clog2(NO_LEVELS), never below one bit
    function automatic int unsigned level_width(input int unsigned no_levels);
        return (no_levels > 1) ? $clog2(no_levels) : 1;
    endfunction

    // Width of a counter that has to hold the value n itself
    function automatic int unsigned count_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, debounce filter, press pulse.
// Latency: press pulse DEBOUNCE_CYCLES+3 cycles after the first low sample.
// Backpressure: none, the one-cycle press pulse cannot be stalled.
module key_debounce
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer; idles high because the key is active-low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after a full run of samples that differ from it;
    // a sample matching the current stable value restarts the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync_b == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_b;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CW'(1);
        end
    end

    // One-cycle pulse on a stable 1->0 transition only; releases are silent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

endmodule

// File: rtl/snake_tick_gen.sv
// Speed-adjustable step strobe for the LED snake, with pause and debounced keys.
// Latency: enable_o every BASE_PERIOD>>level_o cycles; key action DEBOUNCE_CYCLES+4 after sampling.
// Backpressure: none; SNAKE_TICK_SINGLE_STEP_EN turns a faster press while paused into one step.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD     = BASE_PERIOD_DEF,
    parameter int unsigned NO_LEVELS       = NO_LEVELS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                key_faster_ni,
    input  logic                                key_slower_ni,
    input  logic                                key_pause_ni,
    output logic                                enable_o,
    output logic [level_width(NO_LEVELS)-1:0]   level_o,
    output logic                                paused_o
);

    localparam int unsigned LW = level_width(NO_LEVELS);
    localparam int unsigned CW = count_width(BASE_PERIOD);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(NO_LEVELS - 1);

    logic [2:0]    keys_n;
    logic [2:0]    press;
    logic [31:0]   period;
    logic [CW-1:0] last;
    logic [CW-1:0] cnt;
    logic          lvl_up;
    logic          lvl_dn;
`ifdef SNAKE_TICK_SINGLE_STEP_EN
    logic          step;
`endif

    assign keys_n = {key_pause_ni, key_slower_ni, key_faster_ni};

    // One conditioner per key: [0] faster, [1] slower, [2] pause
    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .key_n (keys_n[k]),
            .press (press[k])
        );
    end

    // Period halves per level and bottoms out at one cycle
    always_comb begin
        period = BASE_PERIOD >> level_o;
        if (period == 32'd0) begin
            period = 32'd1;
        end
        last = CW'(period - 32'd1);
    end

    // Decode presses; simultaneous faster+slower cancel, saturated presses do nothing
    always_comb begin
        lvl_up = 1'b0;
        lvl_dn = 1'b0;
`ifdef SNAKE_TICK_SINGLE_STEP_EN
        step   = 1'b0;
        if (press[0] && !press[1]) begin
            step   = paused_o;
            lvl_up = !paused_o && (level_o != LEVEL_MAX);
        end
`else
        if (press[0] && !press[1]) begin
            lvl_up = (level_o != LEVEL_MAX);
        end
`endif
        if (press[1] && !press[0]) begin
            lvl_dn = (level_o != '0);
        end
    end

    // Speed level register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_o <= '0;
        end else if (lvl_up) begin
            level_o <= level_o + LW'(1);
        end else if (lvl_dn) begin
            level_o <= level_o - LW'(1);
        end
    end

    // Pause flag toggles on every pause press
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paused_o <= 1'b0;
        end else if (press[2]) begin
            paused_o <= ~paused_o;
        end
    end

    // Period counter and step strobe; a level change restarts the period,
    // pause freezes the count so resume picks up where it stopped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= '0;
            enable_o <= 1'b0;
        end else if (lvl_up || lvl_dn) begin
            cnt      <= '0;
            enable_o <= 1'b0;
        end else if (!paused_o) begin
            if (cnt == last) begin
                cnt      <= '0;
                enable_o <= 1'b1;
            end else begin
                cnt      <= cnt + CW'(1);
                enable_o <= 1'b0;
            end
        end else begin
`ifdef SNAKE_TICK_SINGLE_STEP_EN
            enable_o <= step;
`else
            enable_o <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_snake_tick_gen.sv
// Bench for snake_tick_gen with BASE_PERIOD=16, NO_LEVELS=4, DEBOUNCE_CYCLES=4.
// Directed tables and sequences plus random key traffic against a reference model.
// Inputs change on the falling edge, outputs are compared on the falling edge.
module tb_snake_tick_gen;

    localparam int BASE = 16;
    localparam int NL   = 4;
    localparam int DEB  = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       kf    = 1'b1;
    logic       ks    = 1'b1;
    logic       kp    = 1'b1;
    logic       en;
    logic [1:0] lvl;
    logic       paused;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snake_tick_gen #(
        .BASE_PERIOD     (BASE),
        .NO_LEVELS       (NL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .key_faster_ni (kf),
        .key_slower_ni (ks),
        .key_pause_ni  (kp),
        .enable_o      (en),
        .level_o       (lvl),
        .paused_o      (paused)
    );

    // ---------------- reference model ----------------
    // Key filter: a key's stable value flips once the last DEB synchronized
    // samples all disagree with it; a 1->0 flip becomes a press that acts
    // two edges later. Timer: a tick every max(1, BASE>>level) running cycles.
    bit hist [3][$];
    bit m_stable [3];
    bit m_fall [3];
    bit m_press [3];
    int m_level;
    int m_cnt;
    bit m_en;
    bit m_paused;

    function automatic int period_of(input int lv);
        int p;
        p = BASE >> lv;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hist[k].delete();
            for (int i = 0; i <= DEB; i++) hist[k].push_front(1'b1);
            m_stable[k] = 1'b1;
            m_fall[k]   = 1'b0;
            m_press[k]  = 1'b0;
        end
        m_level  = 0;
        m_cnt    = 0;
        m_en     = 1'b0;
        m_paused = 1'b0;
    endtask

    task automatic model_step();
        bit kv [3];
        bit pf, ps, pp, up, dn, stp, all_diff;
        kv[0] = kf; kv[1] = ks; kv[2] = kp;
        pf = m_press[0]; ps = m_press[1]; pp = m_press[2];
        up  = pf && !ps && (m_level < NL - 1);
        dn  = ps && !pf && (m_level > 0);
        stp = 1'b0;
`ifdef SNAKE_TICK_SINGLE_STEP_EN
        if (pf && !ps && m_paused) begin
            up  = 1'b0;
            stp = 1'b1;
        end
`endif
        if (up || dn) begin
            m_level = up ? m_level + 1 : m_level - 1;
            m_cnt   = 0;
            m_en    = 1'b0;
        end else if (!m_paused) begin
            if (m_cnt == period_of(m_level) - 1) begin
                m_cnt = 0;
                m_en  = 1'b1;
            end else begin
                m_cnt++;
                m_en = 1'b0;
            end
        end else begin
            m_en = stp;
        end
        if (pp) m_paused = !m_paused;
        for (int k = 0; k < 3; k++) begin
            m_press[k] = m_fall[k];
            m_fall[k]  = 1'b0;
            all_diff   = 1'b1;
            for (int i = 1; i <= DEB; i++)
                if (hist[k][i] == m_stable[k]) all_diff = 1'b0;
            if (all_diff) begin
                m_fall[k]   = m_stable[k];
                m_stable[k] = !m_stable[k];
            end
            hist[k].push_front(kv[k]);
            void'(hist[k].pop_back());
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", {28'd0, en, lvl, paused}, {28'd0, m_en, 2'(m_level), m_paused});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       kf = v;
            1:       ks = v;
            default: kp = v;
        endcase
    endtask

    task automatic press_key(input int k, input int low, input int high);
        set_key(k, 1'b0);
        run(low);
        set_key(k, 1'b1);
        run(high);
    endtask

    task automatic wait_en(input string name);
        int w;
        w = 0;
        while (en !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check(name, 32'(en), 32'd1);
    endtask

    typedef struct {
        int   cyc;
        logic en;
        int   lvl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int ne;
        int w;
        int hold [3];
        logic cur [3];

        tbl = '{'{15, 1'b0, 0}, '{16, 1'b1, 0}, '{17, 1'b0, 0}, '{31, 1'b0, 0},
                '{32, 1'b1, 0}, '{48, 1'b1, 0}, '{63, 1'b0, 0}, '{64, 1'b1, 0}};

        // reset state
        model_reset();
        #12;
        check("reset_en", 32'(en), 32'd0);
        check("reset_lvl", 32'(lvl), 32'd0);
        check("reset_paused", 32'(paused), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle: strobe every 16 cycles
        for (int n = 1; n <= 64; n++) begin
            tick();
            foreach (tbl[t]) begin
                if (tbl[t].cyc == n) begin
                    check($sformatf("idle_en_c%0d", n), 32'(en), 32'(tbl[t].en));
                    check($sformatf("idle_lvl_c%0d", n), 32'(lvl), 32'(tbl[t].lvl));
                end
            end
        end

        // faster held 20 cycles: level changes 8 edges after the key edge, then period 8
        kf = 1'b0;
        run(7);
        check("faster_lvl_early", 32'(lvl), 32'd0);
        run(1);
        check("faster_lvl", 32'(lvl), 32'd1);
        run(7);
        check("faster_no_en", 32'(en), 32'd0);
        run(1);
        check("faster_en_after_clear", 32'(en), 32'd1);
        run(4);
        kf = 1'b1;
        run(12);

        // saturation up and down
        repeat (5) press_key(0, 8, 8);
        check("sat_up_lvl", 32'(lvl), 32'd3);
        wait_en("period2_first");
        tick();
        check("period2_gap", 32'(en), 32'd0);
        tick();
        check("period2_next", 32'(en), 32'd1);
        repeat (5) press_key(1, 8, 8);
        check("sat_dn_lvl", 32'(lvl), 32'd0);

        // bouncing key: only the final settled low counts
        for (int i = 0; i < 10; i++) begin
            kf = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(2);
        end
        kf = 1'b0;
        run(7);
        check("bounce_lvl_early", 32'(lvl), 32'd0);
        run(1);
        check("bounce_lvl", 32'(lvl), 32'd1);
        run(10);
        kf = 1'b1;
        run(10);
        check("bounce_single", 32'(lvl), 32'd1);

        // pause at counter 9, hold 100 cycles, resume after 6 cycles
        press_key(1, 8, 8);
        wait_en("pause_sync");
        run(2);
        kp = 1'b0;
        run(7);
        check("pause_early", 32'(paused), 32'd0);
        run(1);
        check("pause_on", 32'(paused), 32'd1);
        kp = 1'b1;
        ne = 0;
        repeat (100) begin
            tick();
            ne += int'(en);
        end
        check("pause_quiet", 32'(ne), 32'd0);
        kp = 1'b0;
        w = 0;
        while (paused !== 1'b0 && w < 20) begin
            tick();
            w++;
        end
        check("resume_delay", 32'(w), 32'd8);
        kp = 1'b1;
        w = 0;
        while (en !== 1'b1 && w < 30) begin
            tick();
            w++;
        end
        check("resume_first_en", 32'(w), 32'd6);

        // faster while paused
        press_key(2, 8, 8);
        check("pause2_on", 32'(paused), 32'd1);
        ne = 0;
        set_key(0, 1'b0);
        repeat (8) begin
            tick();
            ne += int'(en);
        end
        kf = 1'b1;
        repeat (8) begin
            tick();
            ne += int'(en);
        end
`ifdef SNAKE_TICK_SINGLE_STEP_EN
        check("step_pulses", 32'(ne), 32'd1);
        check("step_lvl", 32'(lvl), 32'd0);
`else
        check("paused_faster_no_en", 32'(ne), 32'd0);
        check("paused_faster_lvl", 32'(lvl), 32'd1);
`endif
        press_key(2, 8, 8);

        // reset mid-period at level 2, paused, with a key press pending
        w = 0;
        while (lvl != 2'd2 && w < 4) begin
            press_key(0, 8, 8);
            w++;
        end
        check("pre_rst_lvl", 32'(lvl), 32'd2);
        press_key(2, 8, 8);
        check("pre_rst_paused", 32'(paused), 32'd1);
        kf = 1'b0;
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {29'd0, en, lvl, paused}, 32'd0);
        model_reset();
        kf = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ne = 0;
        repeat (15) begin
            tick();
            ne += int'(en);
        end
        check("rst_no_early_en", 32'(ne), 32'd0);
        tick();
        check("rst_first_en", 32'(en), 32'd1);
        check("rst_pending_dropped", 32'(lvl), 32'd0);

        // random key traffic against the model
        for (int k = 0; k < 3; k++) begin
            hold[k] = 0;
            cur[k]  = 1'b1;
        end
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    cur[k]  = ~cur[k];
                    hold[k] = int'($urandom_range(1, 14));
                    set_key(k, cur[k]);
                end
                hold[k]--;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
